// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute-stage ALU front end.
//   OP_*    : 3-bit op codes understood by the combinational 32-bit ALU.
//   ALUOP_* : 2-bit main-control aluop classes.
//   FUNCT_* : R-type funct encodings supported by the decoder.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/alu_dec.sv
// alu_dec: purely combinational aluop/funct -> ALU op decoder.
// Ports:
//   aluop   in  2  main-control class (add, sub, funct, or)
//   funct   in  6  R-type funct field, only consulted for the funct class
//   op      out 3  ALU op code
//   illegal out 1  funct class with an unsupported funct (op falls back to add)
module alu_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] op,
  output logic       illegal
);

  // Translate the control class, consulting funct only for R-type.
  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_OR:  op = OP_OR;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: op = OP_ADD;
          FUNCT_SUB, FUNCT_SUBU: op = OP_SUB;
          FUNCT_AND:             op = OP_AND;
          FUNCT_OR:              op = OP_OR;
          FUNCT_SLT:             op = OP_SLT;
          default: begin
            op      = OP_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: execute-stage front end. Decodes the operation, holds the ALU
// operands in an issue register (stage 1) and captures the combinational ALU
// result in a result register (stage 2), with valid/ready on both sides.
// Optional build macro ALU_SKID_EN adds a one-entry skid buffer so in_ready
// comes from a register and has no combinational path from out_ready.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush                    synchronous squash of every in-flight entry
//   in_valid / in_ready      upstream handshake
//   in_aluop, in_funct       operation to decode
//   in_srca, in_srcb, in_imm operand sources; in_alusrc selects in_imm as num2
//   in_tag                   destination register tag
//   alu_num1/alu_num2/alu_op issue register contents driving the ALU
//   alu_result               combinational ALU result
//   out_valid / out_ready    downstream handshake
//   out_result, out_zero, out_tag, out_illegal  registered result fields
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_srca,
  input  logic [WIDTH-1:0] in_srcb,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_alusrc,
  input  logic [TAGW-1:0]  in_tag,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_illegal
);

  // Issue packet layout: {op, num1, num2, tag, illegal}.
  localparam int PW = 3 + 2 * WIDTH + TAGW + 1;

  logic [2:0]       dec_op_s;
  logic             dec_illegal_s;
  logic [WIDTH-1:0] num2_s;
  logic [PW-1:0]    in_pkt_s;
  logic [PW-1:0]    s1_next_s;
  logic [PW-1:0]    s1_pkt_r;
  logic             s1_valid_r;
  logic             s1_load_s;
  logic             s1_open_s;
  logic             s2_load_s;
  logic [TAGW-1:0]  s1_tag_s;
  logic             s1_illegal_s;

  alu_dec u_dec (
    .aluop   (in_aluop),
    .funct   (in_funct),
    .op      (dec_op_s),
    .illegal (dec_illegal_s)
  );

  assign num2_s   = in_alusrc ? in_imm : in_srcb;
  assign in_pkt_s = {dec_op_s, in_srca, num2_s, in_tag, dec_illegal_s};

  assign {alu_op, alu_num1, alu_num2, s1_tag_s, s1_illegal_s} = s1_pkt_r;

  assign s2_load_s = s1_valid_r && (!out_valid || out_ready);
  // Stage 1 can take a new entry if empty or if its entry moves on this edge.
  assign s1_open_s = !s1_valid_r || s2_load_s;

`ifdef ALU_SKID_EN
  logic          skid_valid_r;
  logic [PW-1:0] skid_pkt_r;
  logic          accept_s;

  assign in_ready  = !skid_valid_r;
  assign accept_s  = in_valid && in_ready && !flush;
  // The skid entry is always older than anything upstream, so it goes first.
  assign s1_load_s = !flush && s1_open_s && (skid_valid_r || accept_s);
  assign s1_next_s = skid_valid_r ? skid_pkt_r : in_pkt_s;

  // Skid buffer: parks an accepted entry when stage 1 cannot take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_r <= 1'b0;
      skid_pkt_r   <= {PW{1'b0}};
    end else if (flush) begin
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r && s1_open_s) begin
      skid_valid_r <= 1'b0;
    end else if (accept_s && !s1_open_s) begin
      skid_valid_r <= 1'b1;
      skid_pkt_r   <= in_pkt_s;
    end
  end
`else
  assign in_ready  = !flush && s1_open_s;
  assign s1_load_s = in_valid && in_ready;
  assign s1_next_s = in_pkt_s;
`endif

  // Issue register: holds the ALU operands steady until stage 2 takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_pkt_r   <= {PW{1'b0}};
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_pkt_r   <= s1_next_s;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Result register: captures the ALU output and holds it under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= {WIDTH{1'b0}};
      out_zero    <= 1'b0;
      out_tag     <= {TAGW{1'b0}};
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load_s) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_zero    <= (alu_result == {WIDTH{1'b0}});
      out_tag     <= s1_tag_s;
      out_illegal <= s1_illegal_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Execute-stage front end that produces the 3-bit op and the num1/num2 operands for the combinational 32-bit ALU, then captures the ALU result.
- Decodes the main-control aluop and the R-type funct field into the ALU op code.
- Holds operands in an issue register and the result in a result register, with valid/ready handshakes on both sides.
- Sits between the ID/EX boundary and the EX/MEM boundary of the MIPS core.

Parameters:
WIDTH, 32, datapath width of operands and result. Must match the ALU, so it is fixed at 32 in this core.
TAGW, 5, width of the destination-register tag carried alongside the operation.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all in-flight entries
in_valid  in  1  upstream holds a valid operation
in_ready  out  1  block accepts when in_valid && in_ready
in_aluop  in  2  00=add, 01=sub, 10=use funct, 11=or (ori)
in_funct  in  6  R-type funct field
in_srca  in  WIDTH  rs value
in_srcb  in  WIDTH  rt value
in_imm  in  WIDTH  sign/zero-extended immediate
in_alusrc  in  1  1 selects in_imm as num2
in_tag  in  TAGW  destination register
alu_num1  out  WIDTH  to ALU num1, driven from the issue register
alu_num2  out  WIDTH  to ALU num2, driven from the issue register
alu_op  out  3  to ALU op, driven from the issue register
alu_result  in  WIDTH  combinational ALU result
out_valid  out  1  result register valid
out_ready  in  1  downstream accepts
out_result  out  WIDTH  registered result
out_zero  out  1  registered (result == 0)
out_tag  out  TAGW  tag of the result
out_illegal  out  1  funct was not a supported encoding

Behaviour:
- Reset: rst_n low asynchronously clears s1_valid, s2_valid, out_valid, out_result, out_zero, out_tag, out_illegal, alu_num1, alu_num2 and alu_op to 0.
- in_ready is 1 after reset.
- Decode (combinational, applied before the issue register):
  - aluop 00 -> op 010
  - aluop 01 -> op 110
  - aluop 11 -> op 001
  - aluop 10 with funct 100000 or 100001 -> op 010
  - funct 100010 or 100011 -> op 110
  - funct 100100 -> op 000
  - funct 100101 -> op 001
  - funct 101010 -> op 111
  - any other funct -> op 010 with illegal=1
- Op 111 is an unsigned less-than producing 0 or 1. Add and subtract wrap modulo 2^32; no overflow flag is produced.
- num2 = in_alusrc ? in_imm : in_srcb. num1 = in_srca.
- Stage 1 (issue register): holds op, num1, num2, tag and illegal.
- Stage 2 (result register): holds result, zero, tag and illegal.
- s2_load = s1_valid && (!s2_valid || out_ready).
- s1_load = in_valid && in_ready.
- in_ready = !flush && (!s1_valid || s2_load). This path is combinational to out_ready when ALU_SKID_EN is undefined.
- Latency: accepted at edge k -> out_valid=1 from edge k+1. Throughput is 1 per cycle when out_ready is held at 1.
- out_valid && !out_ready: out_result, out_zero, out_tag and out_illegal hold stable. The issue register holds. in_ready=0 once s1 is occupied.
- The issue register drives the ALU continuously; its contents are unchanged while stalled.
- Simultaneous s1 drain and load in the same cycle is allowed; the new entry replaces the old.
- flush=1 at an edge clears s1_valid and s2_valid, so out_valid=0 next cycle. No new entry is accepted in that cycle. Flush has priority over all loads.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro ALU_SKID_EN.
- Defined:
  - in_ready becomes a register, equal to !skid_valid.
  - A one-entry skid buffer captures an accepted operation when s1 cannot load.
  - Throughput is unchanged; latency is +1 only for an entry that lands in the skid buffer.
  - Flush also clears skid_valid.
  - There is no combinational path from out_ready to in_ready.
- Undefined: no skid buffer; behaviour is exactly as described above.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams OP_AND=000, OP_OR=001, OP_ADD=010, OP_ANDN=100, OP_ORN=101, OP_SUB=110, OP_SLT=111
  - ALUOP_* codes
  - FUNCT_* codes
- One natural sub-module: alu_dec, a purely combinational aluop/funct -> op/illegal decoder that the bench can reuse as a reference model.

Test Plan:
- Reset then aluop=10, funct=100000, srca=5, srcb=7, alusrc=0, out_ready=1 -> alu_op=010; out_result=12 and out_zero=0 with out_valid on the second cycle after accept.
- aluop=10, funct=101010, srca=0xFFFFFFFF, srcb=1 -> out_result=0, because the compare is unsigned. Swapping the operands -> out_result=1.
- aluop=01, srca=srcb=0x1234 -> out_result=0, out_zero=1. Then aluop=00, alusrc=1, imm=0xFFFFFFFC, srca=4 -> out_result=0, out_zero=1.
- Four back-to-back ops with out_ready=0 for 3 cycles -> out_result stable and in_ready=0 after s1 fills; resuming out_ready=1 delivers all four in order with no loss or duplication.
- funct=000000 under aluop=10 -> out_illegal=1, alu_op=010. Flush asserted while two entries are in flight -> out_valid=0 next cycle and neither entry ever appears.
- rst_n pulsed low for half a cycle between edges -> all outputs read 0 immediately. Repeat the backpressure scenario with ALU_SKID_EN defined -> identical output sequence.
